// File: rtl/alu_exec_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_exec_unit_pkg
// Brief  : ALU operation codes, execute-stage FSM encodings, overflow helper.
// Rev    : 1.0
// ============================================================================
package alu_exec_unit_pkg;

  typedef enum logic [2:0] {
    ALU_AND   = 3'b000,
    ALU_OR    = 3'b001,
    ALU_ADD   = 3'b010,
    ALU_SUB   = 3'b011,
    ALU_MULTU = 3'b100,
    ALU_SLT   = 3'b101,
    ALU_SLL   = 3'b110,
    ALU_NOP   = 3'b111
  } alu_op_e;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Two's-complement overflow from operand and result sign bits.
  function automatic logic add_sub_ovf(input logic a_msb, input logic b_msb,
                                       input logic r_msb, input logic is_sub);
    if (is_sub) return (a_msb != b_msb) && (r_msb != a_msb);
    else        return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module : shift_add_multiplier
// Brief  : Unsigned shift-add multiplier, one multiplier bit per cycle.
// Rev    : 1.0
// ============================================================================
module shift_add_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_addend;

  // prod already includes the current iteration, so the final product is
  // valid in the same cycle that done is raised.
  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign prod     = r_acc + w_addend;
  assign busy     = r_busy;
  assign done     = r_busy && (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_acc    <= '0;
      r_mplier <= b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= prod;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_cnt == C_LAST) begin
        r_cnt  <= '0;
        r_busy <= 1'b0;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module : alu_exec_unit
// Brief  : Handshaked execute stage; single-cycle ALU ops plus iterative MULTU.
//          Define OVF_DETECT_EN to report signed ADD/SUB overflow.
// Rev    : 1.0
// ============================================================================
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow
);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic               r_in_ready;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_zero;
  logic               r_ovf;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;

  assign w_is_mul = (alu_ctrl == ALU_MULTU);
  assign w_accept = in_valid && r_in_ready;

  shift_add_multiplier #(
    .WIDTH (WIDTH),
    .CNT_W (SHAMT_W)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (w_accept && w_is_mul),
    .a     (src_a),
    .b     (src_b),
    .busy  (w_mul_busy),
    .done  (w_mul_done),
    .prod  (w_prod)
  );

  // in_ready is registered so it stays low through reset and rises on the first edge after.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state == S_IDLE);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = w_is_mul ? S_MUL : S_DONE;
      S_MUL:   if (w_mul_busy && w_mul_done) w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = r_in_ready;
    out_valid = (r_state == S_DONE);
    result    = r_result;
    result_hi = r_result_hi;
    zero      = r_zero;
    overflow  = r_ovf;
  end

  always_comb begin
    w_sum  = src_a + src_b;
    w_diff = src_a - src_b;
    w_res  = '0;
    w_ovf  = 1'b0;
    case (alu_op_e'(alu_ctrl))
      ALU_AND: w_res = src_a & src_b;
      ALU_OR:  w_res = src_a | src_b;
      ALU_ADD: w_res = w_sum;
      ALU_SUB: w_res = w_diff;
      ALU_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLL: w_res = src_b << src_a[SHAMT_W-1:0];
      default: w_res = '0;
    endcase
`ifdef OVF_DETECT_EN
    if (alu_ctrl == ALU_ADD)
      w_ovf = add_sub_ovf(src_a[WIDTH-1], src_b[WIDTH-1], w_sum[WIDTH-1], 1'b0);
    else if (alu_ctrl == ALU_SUB)
      w_ovf = add_sub_ovf(src_a[WIDTH-1], src_b[WIDTH-1], w_diff[WIDTH-1], 1'b1);
`endif
  end

  // Output registers load only on accept or MUL completion, so they hold through backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_result    <= w_res;
      r_result_hi <= '0;
      r_zero      <= (w_res == '0);
      r_ovf       <= w_ovf;
    end else if ((r_state == S_MUL) && w_mul_done) begin
      r_result    <= w_prod[WIDTH-1:0];
      r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
      r_zero      <= (w_prod[WIDTH-1:0] == '0);
      r_ovf       <= 1'b0;
    end
  end

endmodule
`default_nettype wire
